// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if
//   Signal bundle between the keypad scanner and the logic around it.
//   master : board/controller side (drives enable and the column returns)
//   slave  : scanner side (drives row selects and the key event outputs)
//   Signals:
//     enable       scanner active when 1
//     col_n[3:0]   column returns, active-low, asynchronous to clk
//     row_n[3:0]   row drive, active-low, one-hot-low while enabled
//     key_code     last accepted key, row*4+col
//     key_valid    one-cycle pulse on an accepted press
//     key_held     level, accepted key still pressed
//     key_release  one-cycle pulse on an accepted release
interface keypad_matrix_scanner_if;
  logic       enable;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;

  modport master (
    output enable,
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  key_release
  );

  modport slave (
    input  enable,
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_held,
    output key_release
  );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a 4x4 key matrix by pulling one row low at a time, reads the
//   active-low column returns through a 2-flop synchronizer, debounces the
//   first key found and reports one code per press and one pulse per release.
//   Ports:
//     clk   scan clock
//     rst   asynchronous, active-high reset
//     kp    keypad_matrix_scanner_if.slave (enable, col_n in; row_n,
//           key_code, key_valid, key_held, key_release out)
//   Parameters:
//     SCAN_DIV         cycles a row is driven before its columns are sampled
//     DEBOUNCE_CYCLES  stable cycles needed to accept a press or a release
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   SCAN     | stepping through rows, sampling columns at end of each dwell
//   DB_PRESS | candidate key found, counting stable low samples
//   HELD     | press accepted, watching the candidate column for release
//   DB_REL   | candidate column went high, counting stable high samples
module keypad_matrix_scanner #(
  parameter int SCAN_DIV        = 10,
  parameter int DEBOUNCE_CYCLES = 200
) (
  input logic                     clk,
  input logic                     rst,
  keypad_matrix_scanner_if.slave  kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    col_m, col_s;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic [BW-1:0] db_cnt, db_cnt_nxt;
  logic [1:0]    cand_row, cand_row_nxt;
  logic [1:0]    cand_col, cand_col_nxt;
  logic          scan_on;
  logic [3:0]    row_n_nxt;
  logic [3:0]    key_code_nxt;
  logic          key_valid_nxt;
  logic          key_held_nxt;
  logic          key_release_nxt;
  logic [1:0]    low_col;
  logic          cand_bit;

  // Column returns are asynchronous; nothing downstream looks at col_n.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= kp.col_n;
      col_s <= col_m;
    end
  end

  // Lowest-numbered low column wins when several keys share the row.
  always_comb begin
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) low_col = 2'(i);
    end
  end

  assign cand_bit = col_s[cand_col];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SCAN;
      row_idx        <= 2'd0;
      dwell          <= '0;
      db_cnt         <= '0;
      cand_row       <= 2'd0;
      cand_col       <= 2'd0;
      scan_on        <= 1'b0;
      kp.row_n       <= 4'hF;
      kp.key_code    <= 4'd0;
      kp.key_valid   <= 1'b0;
      kp.key_held    <= 1'b0;
      kp.key_release <= 1'b0;
    end else begin
      state          <= state_nxt;
      row_idx        <= row_idx_nxt;
      dwell          <= dwell_nxt;
      db_cnt         <= db_cnt_nxt;
      cand_row       <= cand_row_nxt;
      cand_col       <= cand_col_nxt;
      scan_on        <= kp.enable;
      kp.row_n       <= row_n_nxt;
      kp.key_code    <= key_code_nxt;
      kp.key_valid   <= key_valid_nxt;
      kp.key_held    <= key_held_nxt;
      kp.key_release <= key_release_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    row_idx_nxt     = row_idx;
    dwell_nxt       = dwell;
    db_cnt_nxt      = db_cnt;
    cand_row_nxt    = cand_row;
    cand_col_nxt    = cand_col;
    key_code_nxt    = kp.key_code;
    key_valid_nxt   = 1'b0;
    key_held_nxt    = kp.key_held;
    key_release_nxt = 1'b0;

    if (!kp.enable) begin
      state_nxt    = SCAN;
      row_idx_nxt  = 2'd0;
      dwell_nxt    = '0;
      db_cnt_nxt   = '0;
      key_held_nxt = 1'b0;
    end else begin
      unique case (state)
        SCAN: begin
          // scan_on is low on the first enabled edge, while row_n is still
          // idle; holding the dwell there gives row 0 its full dwell.
          if (scan_on) begin
            if (dwell == DWELL_LAST) begin
              dwell_nxt = '0;
              if (col_s != 4'hF) begin
                cand_row_nxt = row_idx;
                cand_col_nxt = low_col;
                db_cnt_nxt   = '0;
                state_nxt    = DB_PRESS;
              end else begin
                row_idx_nxt = row_idx + 2'd1;
              end
            end else begin
              dwell_nxt = dwell + 1'b1;
            end
          end
        end

        DB_PRESS: begin
          if (!cand_bit) begin
            if (db_cnt == DB_LAST) begin
              key_code_nxt  = {cand_row, cand_col};
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              db_cnt_nxt    = '0;
              state_nxt     = HELD;
            end else begin
              db_cnt_nxt = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_nxt  = '0;
            dwell_nxt   = '0;
            row_idx_nxt = row_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end

        HELD: begin
          if (cand_bit) begin
            db_cnt_nxt = '0;
            state_nxt  = DB_REL;
          end
        end

        DB_REL: begin
          if (cand_bit) begin
            if (db_cnt == DB_LAST) begin
              key_held_nxt    = 1'b0;
              key_release_nxt = 1'b1;
              db_cnt_nxt      = '0;
              dwell_nxt       = '0;
              row_idx_nxt     = row_idx + 2'd1;
              state_nxt       = SCAN;
            end else begin
              db_cnt_nxt = db_cnt + 1'b1;
            end
          end else begin
            db_cnt_nxt = '0;
            state_nxt  = HELD;
          end
        end

        default: state_nxt = SCAN;
      endcase
    end

    row_n_nxt = kp.enable ? ~(4'b0001 << row_idx_nxt) : 4'hF;
  end

endmodule
